// File: rtl/fp16_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_to_int
//  Description : Serial IEEE-754 half-precision to 16-bit two's-complement
//                integer converter. The fraction is truncated toward zero,
//                one mantissa bit is shifted out per clock, and values whose
//                magnitude exceeds 2048 (plus inf/NaN) raise an error pulse.
//
//  Ports
//    clk        in   1   rising-edge clock
//    reset      in   1   asynchronous active-low reset
//    dataIn     in  16   half-float {sign, exp[4:0], mant[9:0]}
//    R_I        in   1   conversion request, sampled only while idle
//    dataOut    out 16   signed result, held until the next completion
//    R_O        out  1   one-cycle completion pulse
//    REG_ERROR  out  1   one-cycle error pulse, coincident with R_O
//
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_to_int (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic        R_I,
    output logic [15:0] dataOut,
    output logic        R_O,
    output logic        REG_ERROR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SHIFT  = 3'd2,
        S_NEGATE = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [4:0]  c_EXP_ONE   = 5'd15;   // biased exponent of 1.0
    localparam logic [4:0]  c_EXP_BASE  = 5'd25;   // exponent needing no shift of {1,m}
    localparam logic [4:0]  c_EXP_MAX   = 5'd26;   // only 2048 exactly is legal here
    localparam logic [15:0] c_MAG_LIMIT = 16'h0800;

    state_t      r_state;
    logic [15:0] r_in;
    logic [15:0] r_mag;
    logic [3:0]  r_count;

    // Field decode of the captured word
    logic        w_sign;
    logic [4:0]  w_exp;
    logic [9:0]  w_man;
    logic        w_is_err;
    logic        w_is_zero;
    logic [4:0]  w_shift_amt;
    logic [15:0] w_mag_init;
    logic [15:0] w_mag_neg;

    assign w_sign = r_in[15];
    assign w_exp  = r_in[14:10];
    assign w_man  = r_in[9:0];

    // e >= 27 also covers inf/NaN (e = 31); at e = 26 any nonzero mantissa
    // pushes the magnitude past 2048.
    assign w_is_err  = (w_exp > c_EXP_MAX) ||
                       ((w_exp == c_EXP_MAX) && (w_man != 10'd0));

    // Zero, subnormals and |x| < 1 all truncate to zero; the sign is dropped
    // so -0 and negative fractions never become a negated zero.
    assign w_is_zero = (w_exp < c_EXP_ONE);

    // 2048 is loaded directly with no shifting; otherwise the hidden-one
    // mantissa is right-aligned by (25 - e) single-bit shifts.
    assign w_shift_amt = (w_exp == c_EXP_MAX) ? 5'd0 : (c_EXP_BASE - w_exp);
    assign w_mag_init  = (w_exp == c_EXP_MAX) ? c_MAG_LIMIT : {5'd0, 1'b1, w_man};
    assign w_mag_neg   = (~r_mag) + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_in      <= 16'd0;
            r_mag     <= 16'd0;
            r_count   <= 4'd0;
            dataOut   <= 16'd0;
            R_O       <= 1'b0;
            REG_ERROR <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    R_O       <= 1'b0;
                    REG_ERROR <= 1'b0;
                    if (R_I) begin
                        r_in    <= dataIn;
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (w_is_err) begin
                        dataOut   <= 16'd0;
                        R_O       <= 1'b1;
                        REG_ERROR <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (w_is_zero) begin
                        dataOut <= 16'd0;
                        R_O     <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mag   <= w_mag_init;
                        r_count <= w_shift_amt[3:0];
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (r_count != 4'd0) begin
                        r_mag   <= r_mag >> 1;
                        r_count <= r_count - 4'd1;
                    end else if (w_sign) begin
                        r_state <= S_NEGATE;
                    end else begin
                        dataOut <= r_mag;
                        R_O     <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_NEGATE: begin
                    r_mag   <= w_mag_neg;
                    dataOut <= w_mag_neg;
                    R_O     <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    R_O     <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    R_O       <= 1'b0;
                    REG_ERROR <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    R_O       <= 1'b0;
                    REG_ERROR <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_to_int
//  Description : Self-checking bench for fp16_to_int. Expected results are
//                queued when a request is sampled and compared when R_O
//                pulses, including the latency from the sampling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp16_to_int;

    logic        clk;
    logic        reset;
    logic [15:0] dataIn;
    logic        R_I;
    logic [15:0] dataOut;
    logic        R_O;
    logic        REG_ERROR;

    fp16_to_int dut (
        .clk       (clk),
        .reset     (reset),
        .dataIn    (dataIn),
        .R_I       (R_I),
        .dataOut   (dataOut),
        .R_O       (R_O),
        .REG_ERROR (REG_ERROR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        err;
        int          lat;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every R_O pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (reset && R_O) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_R_O: got dataOut=%h err=%b expected no completion (t=%0t)",
                         dataOut, REG_ERROR, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check16($sformatf("data[%h]", e.din), dataOut, e.dout);
                check16($sformatf("err[%h]", e.din), {15'd0, REG_ERROR}, {15'd0, e.err});
                check16($sformatf("latency[%h]", e.din), 16'(cyc - e.k), 16'(e.lat));
            end
        end else if (reset && REG_ERROR) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_without_R_O: got REG_ERROR=1 expected 0 (t=%0t)", $time);
        end
    end

    // Issue one request; returns the index of the edge that sampled it.
    task automatic request(input logic [15:0] d, output int k);
        @(negedge clk);
        dataIn = d;
        R_I    = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        R_I = 1'b0;
    endtask

    task automatic push(input vec_t v, input int k);
        exp_t e;
        e.din  = v.din;
        e.dout = v.dout;
        e.err  = v.err;
        e.lat  = v.lat;
        e.k    = k;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d completions outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] di, input logic [15:0] dq,
                                input logic er, input int la);
        vec_t v;
        v.din  = di;
        v.dout = dq;
        v.err  = er;
        v.lat  = la;
        return v;
    endfunction

    initial begin
        int k;
        vec_t v;

        reset  = 1'b0;
        R_I    = 1'b0;
        dataIn = 16'h0000;

        // latency = 2 + (25 - e) + sign for normal; 1 for zero/error
        vecs.push_back(mk(16'h3C00, 16'h0001, 1'b0, 12));
        vecs.push_back(mk(16'h4D48, 16'h0015, 1'b0, 8));
        vecs.push_back(mk(16'hC500, 16'hFFFB, 1'b0, 11));
        vecs.push_back(mk(16'hCD48, 16'hFFEB, 1'b0, 9));
        vecs.push_back(mk(16'h6800, 16'h0800, 1'b0, 2));
        vecs.push_back(mk(16'hE800, 16'hF800, 1'b0, 3));
        vecs.push_back(mk(16'h67FF, 16'h07FF, 1'b0, 2));
        vecs.push_back(mk(16'hE7FF, 16'hF801, 1'b0, 3));
        vecs.push_back(mk(16'h5000, 16'h0020, 1'b0, 7));
        vecs.push_back(mk(16'h6801, 16'h0000, 1'b1, 1));
        vecs.push_back(mk(16'h6C00, 16'h0000, 1'b1, 1));
        vecs.push_back(mk(16'h7C00, 16'h0000, 1'b1, 1));
        vecs.push_back(mk(16'h7E00, 16'h0000, 1'b1, 1));
        vecs.push_back(mk(16'hFFFF, 16'h0000, 1'b1, 1));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 1));
        vecs.push_back(mk(16'h8000, 16'h0000, 1'b0, 1));
        vecs.push_back(mk(16'h0001, 16'h0000, 1'b0, 1));
        vecs.push_back(mk(16'h3BFF, 16'h0000, 1'b0, 1));
        vecs.push_back(mk(16'hBBFF, 16'h0000, 1'b0, 1));

        // Reset state
        repeat (3) @(negedge clk);
        check16("rst_dataOut", dataOut, 16'h0000);
        check16("rst_R_O", {15'd0, R_O}, 16'h0000);
        check16("rst_REG_ERROR", {15'd0, REG_ERROR}, 16'h0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven conversions; result must also hold afterwards
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            request(v.din, k);
            push(v, k);
            drain(40);
            repeat (2) @(negedge clk);
            check16($sformatf("hold[%h]", v.din), dataOut, v.dout);
        end

        // Request during SHIFT is ignored
        request(16'h3C00, k);
        push(mk(16'h3C00, 16'h0001, 1'b0, 12), k);
        repeat (2) @(negedge clk);
        dataIn = 16'h5000;
        R_I    = 1'b1;
        @(negedge clk);
        R_I    = 1'b0;
        drain(40);
        repeat (15) @(negedge clk);
        check16("busy_hold", dataOut, 16'h0001);

        // Held request: captures every 4 edges for a 2-edge conversion
        @(negedge clk);
        dataIn = 16'h6800;
        R_I    = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        for (int j = 0; j < 3; j++) push(mk(16'h6800, 16'h0800, 1'b0, 2), k + 4 * j);
        repeat (11) @(negedge clk);
        R_I = 1'b0;
        drain(20);
        repeat (6) @(negedge clk);

        // Reset mid-SHIFT: outputs clear at once, conversion discarded
        request(16'h4D48, k);
        push(mk(16'h4D48, 16'h0015, 1'b0, 8), k);
        drain(20);
        request(16'h3C00, k);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check16("async_rst_dataOut", dataOut, 16'h0000);
        check16("async_rst_R_O", {15'd0, R_O}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check16("post_rst_dataOut", dataOut, 16'h0000);

        // First conversion after reset release
        request(16'hC000, k);
        push(mk(16'hC000, 16'hFFFE, 1'b0, 12), k);
        drain(40);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
